// File: rtl/dmem_console_pkg.sv
// rtl/dmem_console_pkg.sv - register offsets, bit indices and status packing for the console port
package dmem_console_pkg;

    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_CTRL   = 2'd2;

    localparam int ST_EMPTY   = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_EN      = 3;
    localparam int ST_CNT_LSB = 8;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_FLUSH   = 1;
    localparam int CTRL_OVF_CLR = 2;

    function automatic logic [31:0] status_word(
        input logic [7:0] cnt,
        input logic       en,
        input logic       ovf,
        input logic       full,
        input logic       empty
    );
        logic [31:0] w;
        w                     = '0;
        w[ST_CNT_LSB +: 8]    = cnt;
        w[ST_EN]              = en;
        w[ST_OVF]             = ovf;
        w[ST_FULL]            = full;
        w[ST_EMPTY]           = empty;
        return w;
    endfunction

endpackage

// File: rtl/dmem_console_port_sync_fifo.sv
// rtl/dmem_console_port_sync_fifo.sv - single-clock FIFO with flush, unreset storage
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    // Caller guarantees push only when not full (or popping) and pop only when not empty.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/dmem_console_port.sv
// rtl/dmem_console_port.sv - memory-mapped console: TXDATA/STATUS/CTRL registers feeding a byte stream
module dmem_console_port #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0100,
    parameter int          DEPTH     = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] dmem_A_i,
    input  logic [31:0] dmem_WD_i,
    input  logic        dmem_WE_i,
    input  logic [3:0]  dmem_WMASK_i,
    output logic [31:0] dmem_RD_o,
    output logic        sel_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i
);
    import dmem_console_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    logic [1:0]    offset;
    logic          wr_txdata, wr_ctrl;
    logic          fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
    logic          ovf_set;
    logic [CW-1:0] fifo_count;
    logic [7:0]    cnt8;
    logic          enable_q, enable_d;
    logic          ovf_q, ovf_d;
    logic          unused_bits;

    assign sel_o     = (dmem_A_i[31:4] == BASE_ADDR[31:4]);
    assign offset    = dmem_A_i[3:2];
    assign wr_txdata = dmem_WE_i & sel_o & (offset == OFF_TXDATA) & dmem_WMASK_i[0];
    assign wr_ctrl   = dmem_WE_i & sel_o & (offset == OFF_CTRL)   & dmem_WMASK_i[0];

    // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
    assign tx_valid_o = enable_q & ~fifo_empty;
    assign fifo_pop   = tx_valid_o & tx_ready_i;
    assign fifo_push  = wr_txdata & (~fifo_full | fifo_pop);
    assign ovf_set    = wr_txdata & fifo_full & ~fifo_pop;
    assign fifo_flush = wr_ctrl & dmem_WD_i[CTRL_FLUSH];

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .flush_i (fifo_flush),
        .wdata_i (dmem_WD_i[7:0]),
        .rdata_o (tx_data_o),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        enable_d = enable_q;
        ovf_d    = ovf_q;
        if (wr_ctrl) enable_d = dmem_WD_i[CTRL_EN];
        if (wr_ctrl && dmem_WD_i[CTRL_OVF_CLR]) ovf_d = 1'b0;
        else if (ovf_set)                       ovf_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            enable_q <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            enable_q <= enable_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        cnt8          = '0;
        cnt8[CW-1:0]  = fifo_count;
    end

    always_comb begin
        dmem_RD_o = '0;
        if (sel_o) begin
            case (offset)
                OFF_STATUS: dmem_RD_o = status_word(cnt8, enable_q, ovf_q, fifo_full, fifo_empty);
                OFF_CTRL:   dmem_RD_o[CTRL_EN] = enable_q;
                default:    dmem_RD_o = '0;
            endcase
        end
    end

    assign unused_bits = ^{dmem_A_i[1:0], dmem_WD_i[31:8], dmem_WMASK_i[3:1]};

endmodule

// File: tb/tb_dmem_console_port.sv
// tb/tb_dmem_console_port.sv - directed stimulus with a byte scoreboard on the tx stream
module tb_dmem_console_port;

    localparam logic [31:0] BASE = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic [31:0] dmem_A_i = '0;
    logic [31:0] dmem_WD_i = '0;
    logic        dmem_WE_i = 1'b0;
    logic [3:0]  dmem_WMASK_i = '0;
    logic [31:0] dmem_RD_o;
    logic        sel_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i = 1'b0;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  exp_q[$];

    dmem_console_port #(
        .BASE_ADDR (BASE),
        .DEPTH     (8)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .dmem_A_i     (dmem_A_i),
        .dmem_WD_i    (dmem_WD_i),
        .dmem_WE_i    (dmem_WE_i),
        .dmem_WMASK_i (dmem_WMASK_i),
        .dmem_RD_o    (dmem_RD_o),
        .sel_o        (sel_o),
        .tx_data_o    (tx_data_o),
        .tx_valid_o   (tx_valid_o),
        .tx_ready_i   (tx_ready_i)
    );

    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Inputs change just after posedge, so the negedge view predicts the next edge's handshake.
    always @(negedge clk) begin
        if (rst_ni && tx_valid_o && tx_ready_i) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL tx_unexpected: got 0x%02h expected no byte", tx_data_o);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (tx_data_o !== e) begin
                    n_fail++;
                    $display("FAIL tx_byte: got 0x%02h expected 0x%02h", tx_data_o, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        dmem_A_i     = a;
        dmem_WD_i    = d;
        dmem_WE_i    = 1'b1;
        dmem_WMASK_i = m;
        step();
        dmem_WE_i    = 1'b0;
        dmem_WMASK_i = '0;
    endtask

    task automatic push(input logic [7:0] b);
        store(BASE, {24'h0, b}, 4'b0001);
    endtask

    task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        dmem_A_i  = a;
        dmem_WE_i = 1'b0;
        #1;
        check32(name, dmem_RD_o, exp);
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() > 0 && k < 40) begin
            step();
            k++;
        end
        check32({"drain_", name}, exp_q.size(), 0);
    endtask

    initial begin
        // 1: reset, two stores, store-to-valid latency
        step();
        step();
        rst_ni = 1'b1;
        tx_ready_i = 1'b1;
        read_check("t1_reset_status", BASE + 32'h4, 32'h0000_0009);
        check32("t1_valid_before", tx_valid_o, 0);
        exp_q.push_back(8'h41);
        exp_q.push_back(8'h42);
        push(8'h41);
        check32("t1_valid_after_store", tx_valid_o, 1);
        check32("t1_head", tx_data_o, 8'h41);
        push(8'h42);
        step();
        drain("t1");
        read_check("t1_status_idle", BASE + 32'h4, 32'h0000_0009);

        // 2: fill, overflow, drain without the dropped byte
        tx_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(8'(i));
            push(8'(i));
        end
        read_check("t2_status_full", BASE + 32'h4, 32'h0000_080A);
        push(8'hFF);
        read_check("t2_status_ovf", BASE + 32'h4, 32'h0000_080E);
        tx_ready_i = 1'b1;
        drain("t2");

        // 3: push into full FIFO while popping
        store(BASE + 32'h8, 32'h5, 4'b0001);
        tx_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(8'h10 + 8'(i));
            push(8'h10 + 8'(i));
        end
        read_check("t3_status_full", BASE + 32'h4, 32'h0000_080A);
        tx_ready_i = 1'b1;
        exp_q.push_back(8'h55);
        push(8'h55);
        read_check("t3_status_push_pop", BASE + 32'h4, 32'h0000_080A);
        drain("t3");

        // 4: disable, enable, flush
        store(BASE + 32'h8, 32'h0, 4'b0001);
        read_check("t4_ctrl_off", BASE + 32'h8, 32'h0);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(8'h21 + 8'(i));
            push(8'h21 + 8'(i));
        end
        step();
        check32("t4_valid_disabled", tx_valid_o, 0);
        read_check("t4_status_held", BASE + 32'h4, 32'h0000_0300);
        store(BASE + 32'h8, 32'h1, 4'b0001);
        drain("t4");
        store(BASE + 32'h8, 32'h0, 4'b0001);
        push(8'h31);
        push(8'h32);
        read_check("t4_status_two", BASE + 32'h4, 32'h0000_0200);
        store(BASE + 32'h8, 32'h6, 4'b0001);
        read_check("t4_status_flushed", BASE + 32'h4, 32'h0000_0001);
        read_check("t4_ctrl_after_flush", BASE + 32'h8, 32'h0);
        store(BASE + 32'h8, 32'h1, 4'b0001);
        read_check("t4_status_reenabled", BASE + 32'h4, 32'h0000_0009);

        // 5: masked and out-of-window stores
        store(BASE, 32'h0000_0099, 4'b0010);
        read_check("t5_status_nolane0", BASE + 32'h4, 32'h0000_0009);
        dmem_A_i     = BASE + 32'h20;
        dmem_WD_i    = 32'h0000_0098;
        dmem_WE_i    = 1'b1;
        dmem_WMASK_i = 4'b0001;
        #1;
        check32("t5_sel_outside", sel_o, 0);
        check32("t5_rd_outside", dmem_RD_o, 32'h0);
        step();
        dmem_WE_i    = 1'b0;
        dmem_WMASK_i = '0;
        read_check("t5_reserved", BASE + 32'hC, 32'h0);
        check32("t5_sel_inside", sel_o, 1);
        read_check("t5_status_after", BASE + 32'h4, 32'h0000_0009);

        // 6: reset mid-drain
        tx_ready_i = 1'b0;
        exp_q.push_back(8'h61);
        for (int i = 0; i < 4; i++) push(8'h61 + 8'(i));
        tx_ready_i = 1'b1;
        step();
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        check32("t6_valid_after_reset", tx_valid_o, 0);
        read_check("t6_status_reset", BASE + 32'h4, 32'h0000_0009);
        exp_q.push_back(8'h7E);
        push(8'h7E);
        drain("t6");
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
